// File: rtl/mm_pkg.sv
// Shared types and default widths for the MMHelper sequencer slice.
package mm_pkg;

  localparam int MM_DATA_W = 8;
  localparam int MM_N      = 4;
  localparam int MM_OUT_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_ISSUE   = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUTPUT  = 3'd5
  } mm_seq_state_t;

endpackage

// File: rtl/mm_idx_walker.sv
// Row-major (r, c) walker over a rows x cols grid; last_o flags the final cell.
// Advancing from the final cell wraps back to (0, 0).
module mm_idx_walker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic [W-1:0] rows_i,
  input  logic [W-1:0] cols_i,
  output logic [W-1:0] r_o,
  output logic [W-1:0] c_o,
  output logic         last_o
);

  logic [W-1:0] r_q, r_d;
  logic [W-1:0] c_q, c_d;
  logic         row_end;

  assign row_end = (c_q == cols_i - W'(1));
  assign last_o  = row_end && (r_q == rows_i - W'(1));
  assign r_o     = r_q;
  assign c_o     = c_q;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clr_i) begin
      r_d = '0;
      c_d = '0;
    end else if (adv_i) begin
      if (last_o) begin
        r_d = '0;
        c_d = '0;
      end else if (row_end) begin
        r_d = r_q + W'(1);
        c_d = '0;
      end else begin
        c_d = c_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// Drives the MMHelper: loads A then B, issues one compute per C element and streams C out.
// Optional MM_SEQ_CYCLE_CNT_EN adds a saturating op_cycles counter port.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH     = MM_DATA_W,
  parameter int N              = MM_N,
  parameter int OUT_DATA_WIDTH = MM_OUT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [N-1:0]                     dim_m,
  input  logic [N-1:0]                     dim_k,
  input  logic [N-1:0]                     dim_n,
  input  logic                             in_valid,
  input  logic signed [DATA_WIDTH-1:0]     in_data,
  output logic                             in_ready,
  output logic                             hlp_wr_enable,
  output logic                             hlp_compute_enable,
  output logic signed [DATA_WIDTH-1:0]     hlp_in_data,
  output logic [N-1:0]                     hlp_i,
  output logic [N-1:0]                     hlp_j,
  output logic                             hlp_is_first_mat,
  output logic [N-1:0]                     hlp_match_dim,
  input  logic signed [OUT_DATA_WIDTH-1:0] hlp_out_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic signed [OUT_DATA_WIDTH-1:0] res_data,
  output logic                             res_last,
  output logic                             busy,
  output logic                             cfg_err
`ifdef MM_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                      op_cycles
`endif
);

  function automatic logic dim_ok(input logic [N-1:0] d);
    return (d != '0) && (int'(d) <= N);
  endfunction

  mm_seq_state_t state_q, state_d;

  logic [N-1:0] m_q, k_q, n_q;
  logic [N-1:0] rows, cols, idx_r, idx_c;
  logic         idx_last, idx_clr, idx_adv;
  logic         start_ok, accept, beat, res_hs;

  logic                             wr_en_q, cmp_en_q, first_q, cfg_err_q;
  logic signed [DATA_WIDTH-1:0]     in_data_q;
  logic [N-1:0]                     i_q, j_q;
  logic                             res_valid_q, res_last_q, cap_fresh_q;
  logic signed [OUT_DATA_WIDTH-1:0] res_data_q;

  assign start_ok = dim_ok(dim_m) && dim_ok(dim_k) && dim_ok(dim_n);
  assign accept   = (state_q == S_IDLE) && start && start_ok;
  assign beat     = in_valid && in_ready;
  assign res_hs   = (state_q == S_OUTPUT) && res_ready;

  // One walker is time-shared: M x K, then K x N, then M x N for results.
  always_comb begin
    rows = m_q;
    cols = n_q;
    if (state_q == S_LOAD_A) begin
      cols = k_q;
    end else if (state_q == S_LOAD_B) begin
      rows = k_q;
    end
  end

  assign idx_clr = (state_q == S_IDLE);
  assign idx_adv = beat || res_hs;

  mm_idx_walker #(.W(N)) u_walker (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (idx_clr),
    .adv_i  (idx_adv),
    .rows_i (rows),
    .cols_i (cols),
    .r_o    (idx_r),
    .c_o    (idx_c),
    .last_o (idx_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_LOAD_A;
      S_LOAD_A:  if (beat && idx_last) state_d = S_LOAD_B;
      S_LOAD_B:  if (beat && idx_last) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUTPUT;
      S_OUTPUT:  if (res_hs) state_d = idx_last ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    busy     = (state_q != S_IDLE);
  end

  // Compute is registered on leaving ISSUE so it never shares a cycle with the final B write;
  // the helper result is valid from the first OUTPUT cycle and is held locally afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      wr_en_q     <= 1'b0;
      cmp_en_q    <= 1'b0;
      first_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_data_q   <= '0;
      i_q         <= '0;
      j_q         <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      cap_fresh_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      cfg_err_q   <= (state_q == S_IDLE) && start && !start_ok;
      wr_en_q     <= beat;
      first_q     <= beat && (state_q == S_LOAD_A);
      cmp_en_q    <= (state_q == S_ISSUE);
      cap_fresh_q <= (state_q == S_CAPTURE);
      if (accept) begin
        m_q <= dim_m;
        k_q <= dim_k;
        n_q <= dim_n;
      end
      if (beat) begin
        in_data_q <= in_data;
      end
      if (beat || (state_q == S_ISSUE)) begin
        i_q <= idx_r;
        j_q <= idx_c;
      end
      if (cap_fresh_q) begin
        res_data_q <= hlp_out_data;
      end
      if (state_q == S_CAPTURE) begin
        res_valid_q <= 1'b1;
        res_last_q  <= idx_last;
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
      end
    end
  end

  assign hlp_wr_enable      = wr_en_q;
  assign hlp_compute_enable = cmp_en_q;
  assign hlp_in_data        = in_data_q;
  assign hlp_i              = i_q;
  assign hlp_j              = j_q;
  assign hlp_is_first_mat   = first_q;
  assign hlp_match_dim      = k_q;
  assign res_valid          = res_valid_q;
  assign res_last           = res_last_q;
  assign res_data           = cap_fresh_q ? hlp_out_data : res_data_q;
  assign cfg_err            = cfg_err_q;

`ifdef MM_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else if (accept) begin
      cyc_q <= 32'd1;
    end else if (busy && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign op_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with a behavioural MMHelper model.
module tb_mm_sequencer;
  import mm_pkg::*;

  localparam int DW = 8;
  localparam int NN = 4;
  localparam int OW = 20;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [NN-1:0]        dim_m = '0, dim_k = '0, dim_n = '0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_ready;
  logic                 hlp_wr_enable, hlp_compute_enable, hlp_is_first_mat;
  logic signed [DW-1:0] hlp_in_data;
  logic [NN-1:0]        hlp_i, hlp_j, hlp_match_dim;
  logic signed [OW-1:0] hlp_out_data = '0;
  logic                 res_valid, res_last, busy, cfg_err;
  logic                 res_ready = 1'b0;
  logic signed [OW-1:0] res_data;
`ifdef MM_SEQ_CYCLE_CNT_EN
  logic [31:0]          op_cycles;
`endif

  always #5 clk = ~clk;

  mm_sequencer #(.DATA_WIDTH(DW), .N(NN), .OUT_DATA_WIDTH(OW)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .dim_m              (dim_m),
    .dim_k              (dim_k),
    .dim_n              (dim_n),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .hlp_wr_enable      (hlp_wr_enable),
    .hlp_compute_enable (hlp_compute_enable),
    .hlp_in_data        (hlp_in_data),
    .hlp_i              (hlp_i),
    .hlp_j              (hlp_j),
    .hlp_is_first_mat   (hlp_is_first_mat),
    .hlp_match_dim      (hlp_match_dim),
    .hlp_out_data       (hlp_out_data),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_last           (res_last),
    .busy               (busy),
    .cfg_err            (cfg_err)
`ifdef MM_SEQ_CYCLE_CNT_EN
    ,
    .op_cycles          (op_cycles)
`endif
  );

  // Behavioural helper: stores A/B elements, registers the dot product on compute.
  logic signed [DW-1:0] a_mem [NN][NN];
  logic signed [DW-1:0] b_mem [NN][NN];
  int wr_cnt = 0, cmp_cnt = 0, ovl_cnt = 0;

  function automatic int dot(input int i, input int j, input int md);
    int s = 0;
    for (int k = 0; k < NN; k++)
      if (k < md) s += int'(a_mem[i][k]) * int'(b_mem[k][j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (hlp_wr_enable) begin
      wr_cnt <= wr_cnt + 1;
      if (hlp_is_first_mat) a_mem[hlp_i][hlp_j] <= hlp_in_data;
      else                  b_mem[hlp_i][hlp_j] <= hlp_in_data;
    end
    if (hlp_compute_enable) begin
      cmp_cnt      <= cmp_cnt + 1;
      hlp_out_data <= OW'(dot(int'(hlp_i), int'(hlp_j), int'(hlp_match_dim)));
    end
    if (hlp_wr_enable && hlp_compute_enable) ovl_cnt <= ovl_cnt + 1;
  end

  typedef struct packed {
    logic [3:0]        m, k, n;
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][19:0] c;
    logic              stall;
    logic              gaps;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int m, input int k, input int n,
                              input int a[16], input int b[16], input int c[16],
                              input bit stall, input bit gaps);
    vec_t v;
    v.m = 4'(m); v.k = 4'(k); v.n = 4'(n);
    for (int e = 0; e < 16; e++) begin
      v.a[e] = 8'(a[e]);
      v.b[e] = 8'(b[e]);
      v.c[e] = 20'(c[e]);
    end
    v.stall = stall;
    v.gaps  = gaps;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int na, nb, nr, w, wb0, cb0;
    na  = int'(v.m) * int'(v.k);
    nb  = int'(v.k) * int'(v.n);
    nr  = int'(v.m) * int'(v.n);
    wb0 = wr_cnt;
    cb0 = cmp_cnt;
    res_ready = !v.stall;
    @(negedge clk);
    start = 1'b1; dim_m = v.m; dim_k = v.k; dim_n = v.n;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int e = 0; e < na + nb; e++) begin
      if (v.gaps && (e % 3 == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = (e < na) ? v.a[e] : v.b[e - na];
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w != 0) chk("in_ready_wait", w, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int r = 0; r < nr; r++) begin
      w = 0;
      while (!res_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("res_gap", w, 2);
      chk("res_data", int'(res_data), int'($signed(v.c[r])));
      chk("res_last", int'(res_last), (r == nr - 1) ? 1 : 0);
      if (v.stall) begin
        repeat (2) begin
          @(negedge clk);
          chk("stall_valid", int'(res_valid), 1);
          chk("stall_data", int'(res_data), int'($signed(v.c[r])));
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
      if (v.stall) res_ready = 1'b0;
    end
    chk("busy_at_end", int'(busy), 0);
    chk("helper_writes", wr_cnt - wb0, na + nb);
    chk("helper_computes", cmp_cnt - cb0, nr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta[16], tb[16], tc[16];
    int wb0;

    ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tc = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0] = mk(2, 2, 2, ta, tb, tc, 1'b0, 1'b0);
    vecs[2] = mk(2, 2, 2, ta, tb, tc, 1'b1, 1'b1);
    ta = '{-128, -128, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tc = '{65536, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = mk(1, 4, 1, ta, ta, tc, 1'b0, 1'b0);
    ta = '{2, -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tb = '{4, 5, -6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tc = '{8, 10, -12, -12, -15, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = mk(2, 1, 3, ta, tb, tc, 1'b0, 1'b1);
    ta = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tb = '{-2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tc = '{-6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = mk(1, 1, 1, ta, tb, tc, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(hlp_wr_enable), 0);
    chk("rst_cmp_en", int'(hlp_compute_enable), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_last", int'(res_last), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    reset = 1'b1;
    @(negedge clk);

    // Main table: plain 2x2, extreme operands, stalled 2x2 with gaps, 2x1x3
    for (int t = 0; t < 4; t++) begin
      run_vec(vecs[t]);
`ifdef MM_SEQ_CYCLE_CNT_EN
      if (t == 0) chk("op_cycles", int'(op_cycles), 21);
`endif
    end

    // Rejected configurations
    wb0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; dim_m = 4'd2; dim_k = 4'd0; dim_n = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_k0", int'(cfg_err), 1);
    chk("cfg_busy_k0", int'(busy), 0);
    @(negedge clk);
    chk("cfg_err_pulse", int'(cfg_err), 0);
    start = 1'b1; dim_k = 4'd2; dim_n = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_n5", int'(cfg_err), 1);
    chk("cfg_busy_n5", int'(busy), 0);
    @(negedge clk);
    chk("cfg_err_pulse2", int'(cfg_err), 0);
    chk("cfg_no_writes", wr_cnt - wb0, 0);

    // Reset during LOAD_B, with an ignored start while busy
    start = 1'b1; dim_m = 4'd2; dim_k = 4'd2; dim_n = 4'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'sd9;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; dim_k = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", int'(cfg_err), 0);
    chk("busy_in_load_b", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_res_valid", int'(res_valid), 0);
    run_vec(vecs[4]);

    chk("enable_overlap", ovl_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
